// File: rtl/mdu_ex.sv
// mdu_ex: multi-cycle multiply/divide unit for the EX stage.
// Owns HI/LO; results commit after a fixed busy window.
module mdu_ex #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        kill,
    input  logic [3:0]  MDUOpE,
    input  logic [1:0]  MTHILOE,
    input  logic [1:0]  MFHILOE,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    output logic [31:0] MDUOut,
    output logic        Busy,
    output logic        MDUStall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAXC =
        (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAXC + 1);

    logic opMult, opMultu, opDiv, opDivu;
    logic opAny, isDiv;
    logic mtHi, mtLo, mfHi, mfLo;

    assign opMult  = (MDUOpE == 4'd1);
    assign opMultu = (MDUOpE == 4'd2);
    assign opDiv   = (MDUOpE == 4'd3);
    assign opDivu  = (MDUOpE == 4'd4);
    assign opAny   = opMult | opMultu | opDiv | opDivu;
    assign isDiv   = opDiv | opDivu;

    assign mtLo = (MTHILOE == 2'b01);
    assign mtHi = (MTHILOE == 2'b10);
    assign mfLo = (MFHILOE == 2'b01);
    assign mfHi = (MFHILOE == 2'b10);

    logic [CW-1:0] cnt;
    logic [31:0]   pendHi, pendLo;
    logic [31:0]   nxtHi, nxtLo;

    logic signed [63:0] sA64, sB64, sProd;
    logic [63:0]        uProd;
    logic [31:0]        sQuo, sRem, uQuo, uRem;
    logic               divZero, divOvf;

    assign sA64  = {{32{SrcA[31]}}, SrcA};
    assign sB64  = {{32{SrcB[31]}}, SrcB};
    assign sProd = sA64 * sB64;
    assign uProd = {32'd0, SrcA} * {32'd0, SrcB};

    assign sQuo = $signed(SrcA) / $signed(SrcB);
    assign sRem = $signed(SrcA) % $signed(SrcB);
    assign uQuo = SrcA / SrcB;
    assign uRem = SrcA % SrcB;

    assign divZero = (SrcB == 32'd0);
    assign divOvf  = (SrcA == 32'h8000_0000) &&
                     (SrcB == 32'hFFFF_FFFF);

    // Zero divisor and INT_MIN/-1 are fixed up explicitly.
    always_comb begin
        nxtHi = 32'd0;
        nxtLo = 32'd0;
        unique case (1'b1)
            opMult:  {nxtHi, nxtLo} = sProd;
            opMultu: {nxtHi, nxtLo} = uProd;
            opDiv: begin
                if (divZero) begin
                    nxtLo = 32'hFFFF_FFFF;
                    nxtHi = SrcA;
                end else if (divOvf) begin
                    nxtLo = 32'h8000_0000;
                    nxtHi = 32'd0;
                end else begin
                    nxtLo = sQuo;
                    nxtHi = sRem;
                end
            end
            opDivu: begin
                if (divZero) begin
                    nxtLo = 32'hFFFF_FFFF;
                    nxtHi = SrcA;
                end else begin
                    nxtLo = uQuo;
                    nxtHi = uRem;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            HI     <= 32'd0;
            LO     <= 32'd0;
            Busy   <= 1'b0;
            cnt    <= '0;
            pendHi <= 32'd0;
            pendLo <= 32'd0;
        end else if (Busy) begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                HI   <= pendHi;
                LO   <= pendLo;
                Busy <= 1'b0;
            end
        end else if (!kill) begin
            if (opAny) begin
                pendHi <= nxtHi;
                pendLo <= nxtLo;
                cnt    <= isDiv ? CW'(DIV_CYCLES)
                                : CW'(MULT_CYCLES);
                Busy   <= 1'b1;
            end else if (mtHi) begin
                HI <= SrcA;
            end else if (mtLo) begin
                LO <= SrcA;
            end
        end
    end

    assign MDUOut = mfLo ? LO : (mfHi ? HI : 32'd0);

    assign MDUStall = Busy & (opAny | mtHi | mtLo | mfHi | mfLo);

endmodule

// File: tb/tb_mdu_ex.sv
// tb_mdu_ex: directed vector table plus hand sequences
// for stalls, back-to-back ops, MT writes, kill and reset.
module tb_mdu_ex;

    logic        clk = 1'b0;
    logic        reset;
    logic        kill;
    logic [3:0]  MDUOpE;
    logic [1:0]  MTHILOE;
    logic [1:0]  MFHILOE;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic [31:0] MDUOut;
    logic        Busy;
    logic        MDUStall;
    logic [31:0] HI;
    logic [31:0] LO;

    int total = 0;
    int bad   = 0;

    mdu_ex dut (
        .clk      (clk),
        .reset    (reset),
        .kill     (kill),
        .MDUOpE   (MDUOpE),
        .MTHILOE  (MTHILOE),
        .MFHILOE  (MFHILOE),
        .SrcA     (SrcA),
        .SrcB     (SrcB),
        .MDUOut   (MDUOut),
        .Busy     (Busy),
        .MDUStall (MDUStall),
        .HI       (HI),
        .LO       (LO)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string nm,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic waitIdle(output int n);
        n = 0;
        while (Busy && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic waitNoStall(output int n);
        n = 0;
        while (MDUStall && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic idleIn();
        MDUOpE  = 4'd0;
        MTHILOE = 2'b00;
        MFHILOE = 2'b00;
        SrcA    = 32'd0;
        SrcB    = 32'd0;
        kill    = 1'b0;
    endtask

    int n;

    initial begin
        vecs[0] = '{4'd1, 32'hFFFF_FFFE, 32'd3,
                    32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
        vecs[1] = '{4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                    32'hFFFF_FFFE, 32'h0000_0001, 5};
        vecs[2] = '{4'd3, 32'hFFFF_FFF9, 32'd2,
                    32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        vecs[3] = '{4'd4, 32'd7, 32'd0,
                    32'd7, 32'hFFFF_FFFF, 10};
        vecs[4] = '{4'd3, 32'h8000_0000, 32'hFFFF_FFFF,
                    32'd0, 32'h8000_0000, 10};
        vecs[5] = '{4'd4, 32'd100, 32'd7,
                    32'd2, 32'd14, 10};
        vecs[6] = '{4'd3, 32'd7, 32'hFFFF_FFFE,
                    32'd1, 32'hFFFF_FFFD, 10};
        vecs[7] = '{4'd3, 32'hFFFF_FFF9, 32'd0,
                    32'hFFFF_FFF9, 32'hFFFF_FFFF, 10};
        vecs[8] = '{4'd1, 32'h8000_0000, 32'h8000_0000,
                    32'h4000_0000, 32'd0, 5};
        vecs[9] = '{4'd2, 32'h8000_0000, 32'd2,
                    32'd1, 32'd0, 5};

        reset = 1'b0;
        idleIn();
        MDUOpE  = 4'd1;
        MFHILOE = 2'b01;
        #12;
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_out", MDUOut, 32'd0);
        check("rst_stall", {31'd0, MDUStall}, 32'd0);
        @(negedge clk);
        idleIn();
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            MDUOpE = vecs[i].op;
            SrcA   = vecs[i].a;
            SrcB   = vecs[i].b;
            @(negedge clk);
            idleIn();
            waitIdle(n);
            check($sformatf("v%0d_cyc", i), n, vecs[i].cyc);
            check($sformatf("v%0d_hi", i), HI, vecs[i].hi);
            check($sformatf("v%0d_lo", i), LO, vecs[i].lo);
            MFHILOE = 2'b01;
            #1 check($sformatf("v%0d_mflo", i), MDUOut, vecs[i].lo);
            MFHILOE = 2'b10;
            #1 check($sformatf("v%0d_mfhi", i), MDUOut, vecs[i].hi);
            MFHILOE = 2'b11;
            #1 check($sformatf("v%0d_mfnone", i), MDUOut, 32'd0);
            @(negedge clk);
            idleIn();
        end

        // MULT then MFLO held in EX by the stall
        MDUOpE = 4'd1; SrcA = 32'd6; SrcB = 32'd7;
        @(negedge clk);
        idleIn();
        MFHILOE = 2'b01;
        waitNoStall(n);
        check("mflo_stall_cyc", n, 32'd5);
        check("mflo_out", MDUOut, 32'd42);
        check("mflo_busy", {31'd0, Busy}, 32'd0);
        @(negedge clk);
        idleIn();

        // second MULT held behind the first
        MDUOpE = 4'd1; SrcA = 32'd6; SrcB = 32'd7;
        @(negedge clk);
        MDUOpE = 4'd1; SrcA = 32'd3; SrcB = 32'd5;
        waitNoStall(n);
        check("b2b_stall_cyc", n, 32'd5);
        check("b2b_lo1", LO, 32'd42);
        check("b2b_idle", {31'd0, Busy}, 32'd0);
        @(negedge clk);
        idleIn();
        check("b2b_busy2", {31'd0, Busy}, 32'd1);
        waitIdle(n);
        check("b2b_cyc2", n, 32'd5);
        check("b2b_lo2", LO, 32'd15);
        check("b2b_hi2", HI, 32'd0);

        // MT writes and kill
        MTHILOE = 2'b01; SrcA = 32'h0000_ABCD;
        @(negedge clk);
        idleIn();
        check("mtlo_lo", LO, 32'h0000_ABCD);
        check("mtlo_hi", HI, 32'd0);
        MTHILOE = 2'b10; SrcA = 32'h0000_1234; kill = 1'b1;
        @(negedge clk);
        idleIn();
        check("mthi_kill_hi", HI, 32'd0);
        MTHILOE = 2'b10; SrcA = 32'h0000_1234;
        @(negedge clk);
        idleIn();
        check("mthi_hi", HI, 32'h0000_1234);
        check("mthi_lo", LO, 32'h0000_ABCD);
        MTHILOE = 2'b11; SrcA = 32'h5555_5555;
        @(negedge clk);
        idleIn();
        check("mt11_hi", HI, 32'h0000_1234);
        check("mt11_lo", LO, 32'h0000_ABCD);

        // killed start and illegal opcode do nothing
        MDUOpE = 4'd1; SrcA = 32'd2; SrcB = 32'd3; kill = 1'b1;
        @(negedge clk);
        idleIn();
        check("kill_start", {31'd0, Busy}, 32'd0);
        MDUOpE = 4'd5; SrcA = 32'd2; SrcB = 32'd3;
        @(negedge clk);
        idleIn();
        check("op5_busy", {31'd0, Busy}, 32'd0);
        check("op5_lo", LO, 32'h0000_ABCD);

        // op wins over MT; kill mid-flight does not abort
        MDUOpE = 4'd1; SrcA = 32'd2; SrcB = 32'd3;
        MTHILOE = 2'b10;
        @(negedge clk);
        idleIn();
        check("prio_hi", HI, 32'h0000_1234);
        check("prio_busy", {31'd0, Busy}, 32'd1);
        kill = 1'b1;
        waitIdle(n);
        kill = 1'b0;
        check("prio_cyc", n, 32'd5);
        check("prio_lo", LO, 32'd6);
        check("prio_hi2", HI, 32'd0);

        // reset in the middle of a DIVU
        MTHILOE = 2'b10; SrcA = 32'h0000_00AA;
        @(negedge clk);
        idleIn();
        MDUOpE = 4'd4; SrcA = 32'd100; SrcB = 32'd7;
        @(negedge clk);
        idleIn();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rmid_busy", {31'd0, Busy}, 32'd0);
        check("rmid_hi", HI, 32'd0);
        check("rmid_lo", LO, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (15) @(negedge clk);
        check("rmid_busy2", {31'd0, Busy}, 32'd0);
        check("rmid_hi2", HI, 32'd0);
        check("rmid_lo2", LO, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
